// File: rtl/multiword_sub_seq.sv
// ---------------------------------------------------------------------------
// multiword_sub_seq
//   Computes a wide subtraction diff = a - bsub - b_in (mod 2^(N*WORDS)) by
//   time-sharing a single N-bit binarySubtractor, one word per clock, least
//   significant word first. The borrow between words is held in a register.
//   A start/busy/done handshake fronts the datapath.
//
// Ports
//   clk       in   1  rising-edge clock
//   rst_n     in   1  asynchronous active-low reset
//   start     in   1  request, sampled in IDLE or DONE
//   abort     in   1  cancel, sampled in RUN only (wins over start)
//   a         in   W  minuend
//   bsub      in   W  subtrahend
//   b_in      in   1  borrow into the least significant word
//   busy      out  1  high while a word-serial operation is running
//   done      out  1  one-cycle pulse, result outputs refreshed in that cycle
//   diff      out  W  result, held between completions
//   borrow    out  1  final borrow-out (a < bsub + b_in, unsigned)
//   overflow  out  1  signed overflow of the full-width result
//   zero      out  1  diff == 0
//
// Also contains binarySubtractor (the shared word datapath) and
// multiword_sub_seq_chk (protocol assertions on the handshake outputs).
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// binarySubtractor
//   Combinational N-bit subtract with borrow: z = x - y - bIn.
// Ports
//   x, y  in  N  operands
//   bIn   in  1  borrow in
//   z     out N  difference
//   b     out 1  borrow out
//   v     out 1  signed overflow
// ---------------------------------------------------------------------------
module binarySubtractor #(
    parameter int N = 8
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         bIn,
    output logic [N-1:0] z,
    output logic         b,
    output logic         v
);

    logic [N:0] fullDiff_s;

    // One extra bit catches the borrow: a negative result wraps into bit N.
    assign fullDiff_s = {1'b0, x} - {1'b0, y} - {{N{1'b0}}, bIn};
    assign z          = fullDiff_s[N-1:0];
    assign b          = fullDiff_s[N];
    // Overflow when operand signs differ and the result sign differs from x.
    assign v          = (x[N-1] ^ y[N-1]) & (x[N-1] ^ fullDiff_s[N-1]);

endmodule

// ---------------------------------------------------------------------------
// multiword_sub_seq_chk
//   Handshake invariants of multiword_sub_seq.
// Ports
//   clk, rst_n  in  1  clock and reset of the checked block
//   busy, done  in  1  handshake outputs of the checked block
// ---------------------------------------------------------------------------
module multiword_sub_seq_chk (
    input logic clk,
    input logic rst_n,
    input logic busy,
    input logic done
);

    // busy and done are never high together.
    aBusyDoneExclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(busy && done));

    // done is a single-cycle pulse.
    aDonePulse: assert property (@(posedge clk) disable iff (!rst_n)
        done |=> !done);

    // done only ever follows a running operation.
    aDoneAfterBusy: assert property (@(posedge clk) disable iff (!rst_n)
        done |-> $past(busy));

endmodule

// ---------------------------------------------------------------------------
// multiword_sub_seq (top)
// ---------------------------------------------------------------------------
module multiword_sub_seq #(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [N*WORDS-1:0]   a,
    input  logic [N*WORDS-1:0]   bsub,
    input  logic                 b_in,
    output logic                 busy,
    output logic                 done,
    output logic [N*WORDS-1:0]   diff,
    output logic                 borrow,
    output logic                 overflow,
    output logic                 zero
);

    localparam int W     = N * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                      state_r;
    // Operands and partial results are kept as word arrays so the active
    // word can be picked with the index directly.
    logic [WORDS-1:0][N-1:0]     opA_r;
    logic [WORDS-1:0][N-1:0]     opB_r;
    logic [WORDS-1:0][N-1:0]     work_r;
    logic [WORDS-1:0][N-1:0]     resFull_s;
    logic [IDX_W-1:0]            idx_r;
    logic                        chain_r;
    logic [W-1:0]                diff_r;
    logic                        busy_r;
    logic                        done_r;
    logic                        borrow_r;
    logic                        overflow_r;
    logic                        zero_r;

    logic [N-1:0]                subX_s;
    logic [N-1:0]                subY_s;
    logic [N-1:0]                subZ_s;
    logic                        subB_s;
    logic                        subV_s;
    logic                        lastWord_s;

    // Word selection for the shared subtractor and the assembled final result.
    always_comb begin
        subX_s     = opA_r[idx_r];
        subY_s     = opB_r[idx_r];
        lastWord_s = (idx_r == IDX_W'(WORDS - 1));
        // Lower words come from earlier cycles; the top word is this cycle's z.
        resFull_s            = work_r;
        resFull_s[WORDS-1]   = subZ_s;
    end

    binarySubtractor #(
        .N (N)
    ) uSub (
        .x   (subX_s),
        .y   (subY_s),
        .bIn (chain_r),
        .z   (subZ_s),
        .b   (subB_s),
        .v   (subV_s)
    );

    // Sequencer FSM with the operand, chain, work and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            opA_r      <= {W{1'b0}};
            opB_r      <= {W{1'b0}};
            work_r     <= {W{1'b0}};
            idx_r      <= {IDX_W{1'b0}};
            chain_r    <= 1'b0;
            diff_r     <= {W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            borrow_r   <= 1'b0;
            overflow_r <= 1'b0;
            zero_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        // Snapshot the inputs; later input changes are ignored.
                        opA_r   <= a;
                        opB_r   <= bsub;
                        chain_r <= b_in;
                        idx_r   <= {IDX_W{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (abort) begin
                        // Results keep the values of the last completion.
                        idx_r   <= {IDX_W{1'b0}};
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        work_r[idx_r] <= subZ_s;
                        chain_r       <= subB_s;
                        if (lastWord_s) begin
                            diff_r     <= resFull_s;
                            borrow_r   <= subB_s;
                            overflow_r <= subV_s;
                            zero_r     <= (resFull_s == {W{1'b0}});
                            idx_r      <= {IDX_W{1'b0}};
                            busy_r     <= 1'b0;
                            done_r     <= 1'b1;
                            state_r    <= DONE;
                        end else begin
                            idx_r <= idx_r + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    idx_r   <= {IDX_W{1'b0}};
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign diff     = diff_r;
    assign borrow   = borrow_r;
    assign overflow = overflow_r;
    assign zero     = zero_r;

    multiword_sub_seq_chk uChk (
        .clk   (clk),
        .rst_n (rst_n),
        .busy  (busy_r),
        .done  (done_r)
    );

endmodule

// File: tb/tb_multiword_sub_seq.sv
// ---------------------------------------------------------------------------
// tb_multiword_sub_seq
//   Self-checking bench for multiword_sub_seq with N=8, WORDS=4. Expected
//   results come from directed constants and from a wide-arithmetic model.
// ---------------------------------------------------------------------------
module tb_multiword_sub_seq;

    localparam int N     = 8;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [W-1:0] a;
    logic [W-1:0] bsub;
    logic         b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         overflow;
    logic         zero;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multiword_sub_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .a        (a),
        .bsub     (bsub),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .borrow   (borrow),
        .overflow (overflow),
        .zero     (zero)
    );

    // Full-width reference: plain 64-bit arithmetic on the whole operands.
    function automatic void model(input logic [31:0] ma, input logic [31:0] mb,
                                  input logic mbin, output logic [31:0] d,
                                  output logic br, output logic ov, output logic zr);
        longint ua, ub, sa, sb, r, s;
        ua = {32'd0, ma};
        ub = {32'd0, mb};
        sa = {{32{ma[31]}}, ma};
        sb = {{32{mb[31]}}, mb};
        r  = ua - ub - {63'd0, mbin};
        s  = sa - sb - {63'd0, mbin};
        d  = r[31:0];
        br = (ua < ub + {63'd0, mbin});
        ov = (s > SMAX) || (s < SMIN);
        zr = (r[31:0] == 32'd0);
    endfunction

    // Launch one operation and watch it until done (bounded).
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb,
                          input logic tbin, input logic abortAtStart,
                          output int busyCnt, output int lat);
        busyCnt = 0;
        lat     = 0;
        @(negedge clk);
        a = ta; bsub = tb; b_in = tbin; start = 1'b1; abort = abortAtStart;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0; abort = 1'b0;
                a = $urandom; bsub = $urandom; b_in = 1'($urandom);
            end
            if (busy) busyCnt++;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        a = 32'd0; bsub = 32'd0; b_in = 1'b0;
        #12;
        checks++;
        if ({busy, done, borrow, overflow, zero, diff} !== 37'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", {busy, done, borrow, overflow, zero, diff});
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, diff} !== 34'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got %h want 0", {busy, done, diff});
        end
    endtask

    task automatic test_directed();
        logic [31:0] ta [4] = '{32'h00000100, 32'h00000000, 32'h7FFFFFFF, 32'h12345678};
        logic [31:0] tb [4] = '{32'h00000001, 32'h00000001, 32'h80000000, 32'h12345677};
        logic        tc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] ed [4] = '{32'h000000FF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
        logic [2:0]  ef [4] = '{3'b000, 3'b100, 3'b110, 3'b001}; // borrow,ovf,zero
        int bc, lat;
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb[i], tc[i], 1'b0, bc, lat);
            checks++;
            if (lat !== 5 || bc !== 4) begin
                errors++;
                $display("FAIL dir%0d_timing: got lat=%0d busy=%0d want lat=5 busy=4", i, lat, bc);
            end
            checks++;
            if (diff !== ed[i] || {borrow, overflow, zero} !== ef[i]) begin
                errors++;
                $display("FAIL dir%0d_result: got %h/%b want %h/%b", i, diff,
                         {borrow, overflow, zero}, ed[i], ef[i]);
            end
        end
    endtask

    // Runs right after test_directed: results must still hold the last case.
    task automatic test_abort();
        int bc, lat;
        @(negedge clk);
        a = 32'hAAAA5555; bsub = 32'h11112222; b_in = 1'b1; start = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy: got %b want 1", busy);
        end
        a = 32'h00000005; bsub = 32'h00000003; start = 1'b1;
        @(negedge clk);
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        checks++;
        if ({busy, done, borrow, overflow, zero, diff} !== {5'b00001, 32'd0}) begin
            errors++;
            $display("FAIL abort_hold: got %h want %h",
                     {busy, done, borrow, overflow, zero, diff}, {5'b00001, 32'd0});
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_done: got busy=%b done=%b want 0 0", busy, done);
            end
        end
        run_op(32'h00000100, 32'h00000001, 1'b0, 1'b0, bc, lat);
        checks++;
        if (lat !== 5 || diff !== 32'h000000FF || {borrow, overflow, zero} !== 3'b000) begin
            errors++;
            $display("FAIL abort_recover: got lat=%0d %h/%b want lat=5 000000ff/000",
                     lat, diff, {borrow, overflow, zero});
        end
    endtask

    task automatic test_random();
        logic [31:0] ra, rb, d;
        logic rc, br, ov, zr;
        int bc, lat;
        for (int i = 0; i < 24; i++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom);
            if (i % 6 == 1) rb = ra;
            if (i % 6 == 2) rb = ra - 32'd1;
            if (i % 6 == 3) begin ra = 32'h80000000; rb = 32'h00000001; end
            model(ra, rb, rc, d, br, ov, zr);
            run_op(ra, rb, rc, 1'($urandom), bc, lat);
            checks++;
            if (lat !== 5 || bc !== 4 || diff !== d || {borrow, overflow, zero} !== {br, ov, zr}) begin
                errors++;
                $display("FAIL rand%0d: a=%h b=%h bin=%b got lat=%0d busy=%0d %h/%b want 5 4 %h/%b",
                         i, ra, rb, rc, lat, bc, diff, {borrow, overflow, zero}, d, {br, ov, zr});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] eA [20];
        logic [31:0] eB [20];
        logic        eC [20];
        logic [31:0] d;
        logic br, ov, zr, expBusy, expDone;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            eA[k] = $urandom; eB[k] = $urandom; eC[k] = 1'($urandom);
            a = eA[k]; bsub = eB[k]; b_in = eC[k]; start = 1'b1;
            @(negedge clk);
            expDone = (k % 5) == 4;
            expBusy = !expDone;
            checks++;
            if (busy !== expBusy || done !== expDone) begin
                errors++;
                $display("FAIL b2b_hs%0d: got busy=%b done=%b want %b %b", k, busy, done, expBusy, expDone);
            end
            if (expDone) begin
                model(eA[k-4], eB[k-4], eC[k-4], d, br, ov, zr);
                checks++;
                if (diff !== d || {borrow, overflow, zero} !== {br, ov, zr}) begin
                    errors++;
                    $display("FAIL b2b_res%0d: got %h/%b want %h/%b", k, diff,
                             {borrow, overflow, zero}, d, {br, ov, zr});
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int bc, lat;
        run_op(32'h00000000, 32'h00000001, 1'b0, 1'b0, bc, lat);
        checks++;
        if (diff !== 32'hFFFFFFFF || borrow !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got %h/%b want ffffffff/1", diff, borrow);
        end
        @(negedge clk);
        a = 32'h76543210; bsub = 32'h01234567; b_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, borrow, overflow, zero, diff} !== 37'd0) begin
            errors++;
            $display("FAIL reset_mid_run: got %h want 0", {busy, done, borrow, overflow, zero, diff});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_done: got busy=%b done=%b want 0 0", busy, done);
            end
        end
        run_op(32'h00000100, 32'h00000001, 1'b0, 1'b0, bc, lat);
        checks++;
        if (lat !== 5 || diff !== 32'h000000FF) begin
            errors++;
            $display("FAIL reset_recover: got lat=%0d diff=%h want 5 000000ff", lat, diff);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_abort();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
